// File: rtl/sensor_ctrl_pkg.sv
// Shared constants and state encoding for the sensor sample buffer controller.
`ifndef SENSOR_CTRL_PKG_SV
`define SENSOR_CTRL_PKG_SV
package sensor_ctrl_pkg;
    localparam int DATA_SIZE  = 32;
    localparam int ADDR_SIZE  = 6;
    localparam int DEPTH      = 64;
    localparam int COUNT_SIZE = ADDR_SIZE + 1;

    localparam int IDLE_BIT    = 0;
    localparam int REQUEST_BIT = 1;
    localparam int FULL_BIT    = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'b001 << IDLE_BIT,
        REQUEST = 3'b001 << REQUEST_BIT,
        FULL    = 3'b001 << FULL_BIT
    } sensor_ctrl_state_t;

    localparam logic [DATA_SIZE-1:0] EMPTY_DATA = '0;
endpackage
`endif

// File: rtl/sensor_mem.sv
// Sample storage: one synchronous write port, one registered read port.
// Only the read register is reset; the array itself keeps whatever it holds.
module sensor_mem
    import sensor_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we_i,
    input  logic [ADDR_SIZE-1:0] waddr_i,
    input  logic [DATA_SIZE-1:0] wdata_i,
    input  logic [ADDR_SIZE-1:0] raddr_i,
    output logic [DATA_SIZE-1:0] rdata_o
);
    logic [DATA_SIZE-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Read register samples the array before this edge's write lands (old data on collision).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata_o <= EMPTY_DATA;
        else     rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/sensor_ctrl.sv
// Acquires sensor samples into a 64-word buffer while enabled, raises a level
// interrupt when full, and holds the data until the wrapper pulses clear.
module sensor_ctrl
    import sensor_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sctrl_en,
    input  logic                 sctrl_clear,
    input  logic [ADDR_SIZE-1:0] sctrl_addr,
    output logic                 sctrl_interrupt,
    output logic [DATA_SIZE-1:0] sctrl_out,
    output logic                 sensor_en,
    input  logic                 sensor_ready,
    input  logic [DATA_SIZE-1:0] sensor_out
);
    localparam logic [COUNT_SIZE-1:0] FULL_COUNT = COUNT_SIZE'(DEPTH);

    sensor_ctrl_state_t    state_q, state_d;
    logic [COUNT_SIZE-1:0] count_q, count_d;
    logic                  we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        we      = 1'b0;
        // Clear wins over everything, including a sample arriving this cycle.
        if (sctrl_clear) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (sctrl_en && count_q < FULL_COUNT) state_d = REQUEST;
                end
                REQUEST: begin
                    if (sensor_ready) begin
                        we      = 1'b1;
                        count_d = count_q + COUNT_SIZE'(1);
                    end
                    if (count_d == FULL_COUNT) state_d = FULL;
                    else if (!sctrl_en)        state_d = IDLE;
                end
                FULL:    state_d = FULL;
                default: state_d = IDLE;
            endcase
        end
    end

    // Decoded straight from state so reset drops them without waiting for a clock.
    assign sensor_en       = state_q[REQUEST_BIT];
    assign sctrl_interrupt = state_q[FULL_BIT];

    sensor_mem u_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (we),
        .waddr_i (count_q[ADDR_SIZE-1:0]),
        .wdata_i (sensor_out),
        .raddr_i (sctrl_addr),
        .rdata_o (sctrl_out)
    );
endmodule

// File: tb/tb_sensor_ctrl.sv
// Scoreboard bench for sensor_ctrl: a bench-side buffer model supplies read expectations.
module tb_sensor_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        sctrl_en, sctrl_clear;
    logic [5:0]  sctrl_addr;
    logic        sctrl_interrupt;
    logic [31:0] sctrl_out;
    logic        sensor_en, sensor_ready;
    logic [31:0] sensor_out;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mdl [64];
    int          cnt = 0;
    logic [31:0] exp_q [$];

    sensor_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .sctrl_en        (sctrl_en),
        .sctrl_clear     (sctrl_clear),
        .sctrl_addr      (sctrl_addr),
        .sctrl_interrupt (sctrl_interrupt),
        .sctrl_out       (sctrl_out),
        .sensor_en       (sensor_en),
        .sensor_ready    (sensor_ready),
        .sensor_out      (sensor_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One sample the bench expects to be stored at the model's fill pointer.
    task automatic sample(input logic [31:0] d);
        sensor_ready = 1'b1;
        sensor_out   = d;
        mdl[cnt]     = d;
        cnt++;
        step();
        sensor_ready = 1'b0;
    endtask

    task automatic rd(input int a, input string tag);
        sctrl_addr = 6'(a);
        exp_q.push_back(mdl[a]);
        step();
        chk(tag, sctrl_out, exp_q.pop_front());
    endtask

    initial begin
        rst = 1'b1; sctrl_en = 1'b0; sctrl_clear = 1'b0; sctrl_addr = '0;
        sensor_ready = 1'b0; sensor_out = '0;
        step(); step();
        chk("rst_out", sctrl_out, 32'h0);
        chk("rst_en", 32'(sensor_en), 32'h0);
        chk("rst_irq", 32'(sctrl_interrupt), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_en", 32'(sensor_en), 32'h0);
            chk("idle_irq", 32'(sctrl_interrupt), 32'h0);
        end

        // Full fill, back-to-back samples.
        sctrl_en = 1'b1;
        step();
        chk("req_en", 32'(sensor_en), 32'h1);
        for (int i = 0; i < 64; i++) begin
            sample(32'h1000 + 32'(i));
            chk("fill_irq", 32'(sctrl_interrupt), (i == 63) ? 32'h1 : 32'h0);
            chk("fill_en", 32'(sensor_en), (i == 63) ? 32'h0 : 32'h1);
        end

        // Readback in FULL while the sensor keeps strobing junk.
        sensor_ready = 1'b1; sensor_out = 32'hDEAD; sctrl_en = 1'b0;
        for (int a = 0; a < 64; a++) begin
            rd(a, "rd_full");
            chk("full_irq", 32'(sctrl_interrupt), 32'h1);
        end
        rd(5, "rd_keep5");
        sensor_ready = 1'b0;

        // Clear pulse and refill from address 0.
        sctrl_en = 1'b1; sctrl_clear = 1'b1;
        step();
        sctrl_clear = 1'b0;
        cnt = 0;
        chk("clr_irq", 32'(sctrl_interrupt), 32'h0);
        step();
        chk("refill_en", 32'(sensor_en), 32'h1);
        for (int i = 0; i < 10; i++) sample(32'h2000 + 32'(i));
        rd(0, "rd_refill0");
        rd(9, "rd_refill9");
        rd(10, "rd_old10");

        // Clear collides with a sample: the sample is dropped.
        sctrl_clear = 1'b1; sensor_ready = 1'b1; sensor_out = 32'hBEEF;
        step();
        sctrl_clear = 1'b0; sensor_ready = 1'b0;
        cnt = 0;
        chk("clr_en", 32'(sensor_en), 32'h0);
        step();
        sample(32'h3000);
        rd(0, "rd_after_clr0");
        rd(10, "rd_no_beef");
        rd(1, "rd_keep1");

        // Async reset mid-fill at count 30.
        for (int i = 1; i < 30; i++) sample(32'h4000 + 32'(i));
        #2 rst = 1'b1;
        #1;
        chk("arst_en", 32'(sensor_en), 32'h0);
        chk("arst_irq", 32'(sctrl_interrupt), 32'h0);
        step();
        rst = 1'b0;
        cnt = 0;
        step();
        chk("post_rst_en", 32'(sensor_en), 32'h1);
        sample(32'h5000);
        rd(0, "rd_post_rst0");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
